// File: rtl/mix_column_if.sv
// AES state bus into and out of the MixColumns stage.
`timescale 1ns/1ps
interface mix_column_if;
    logic [0:127] dataIn;
    logic [0:127] resMat;

    modport master (
        output dataIn,
        input  resMat
    );

    modport slave (
        input  dataIn,
        output resMat
    );
endinterface

// File: rtl/mix_column.sv
// Registered AES-128 MixColumns stage: each of the four state columns is
// multiplied by the fixed MDS matrix over GF(2^8), with one cycle of latency.
// Byte k of the state occupies bits [8k:8k+7]; column c is bytes 4c..4c+3.
`timescale 1ns/1ps
module mix_column (
    input  logic         clk,
    input  logic         rst,
    mix_column_if.slave  bus
);

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

    logic [0:127] mixed;

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;

        // One independent column of the MDS matrix product.
        always_comb begin
            a0 = bus.dataIn[32*c +: 8];
            a1 = bus.dataIn[32*c + 8 +: 8];
            a2 = bus.dataIn[32*c + 16 +: 8];
            a3 = bus.dataIn[32*c + 24 +: 8];
            b0 = xtime(a0) ^ mul3(a1) ^ a2 ^ a3;
            b1 = a0 ^ xtime(a1) ^ mul3(a2) ^ a3;
            b2 = a0 ^ a1 ^ xtime(a2) ^ mul3(a3);
            b3 = mul3(a0) ^ a1 ^ a2 ^ xtime(a3);
        end

        assign mixed[32*c +: 32] = {b0, b1, b2, b3};
    end

    // Output register, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.resMat <= '0;
        end else begin
            bus.resMat <= mixed;
        end
    end

endmodule

// File: tb/tb_mix_column.sv
// Self-checking bench for mix_column: directed FIPS-197 style vectors, edge
// bytes, asynchronous reset and a random regression against a GF(2^8) model.
`timescale 1ns/1ps
module tb_mix_column;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    mix_column_if mif ();

    mix_column dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    // General GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Reference: state viewed as a 4x4 byte matrix, multiplied by the MDS matrix.
    function automatic logic [127:0] ref_mix(input logic [127:0] s);
        logic [7:0]   m [4][4];
        logic [7:0]   st [4][4];
        logic [7:0]   acc;
        logic [127:0] r;
        m[0] = '{8'd2, 8'd3, 8'd1, 8'd1};
        m[1] = '{8'd1, 8'd2, 8'd3, 8'd1};
        m[2] = '{8'd1, 8'd1, 8'd2, 8'd3};
        m[3] = '{8'd3, 8'd1, 8'd1, 8'd2};
        for (int k = 0; k < 16; k++) st[k % 4][k / 4] = s[127 - 8*k -: 8];
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[row][j], st[j][c]);
                r[127 - 8*(4*c + row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        mif.dataIn = rand128();
        #1;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (mif.resMat !== 128'h0) begin
                $display("FAIL reset_hold t=%0t: got %h expected %h", $time, mif.resMat, 128'h0);
            end else passed++;
            if (i == 2) mif.dataIn = rand128();
            if (i < 5) #2;
        end
        mif.dataIn = 128'h1A5BE9A9AB30D2AA0141D3E827B4BABB;
        #1;
    endtask

    task automatic test_constant();
        logic [127:0] exp;
        exp = 128'h992568D5650CC14BFA05DE5A883A2A0A;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (mif.resMat !== exp) begin
                $display("FAIL constant cycle %0d: got %h expected %h", i, mif.resMat, exp);
            end else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] vin [4];
        logic [127:0] vexp [4];
        vin[0]  = 128'h632FAFA2EB93C7209F92ABCBA0C0302B;
        vexp[0] = 128'hBA75F47A84A48D32E88D060E1B407D5D;
        vin[1]  = 128'h6A4E988B59489E3DCB1230F4BDA09B9B;
        vexp[1] = 128'h15CE8965C94D71477F4BBE979ACB86CA;
        vin[2]  = 128'hBC389AA151EB1820EE120426B338FF39;
        vexp[2] = 128'h10D85324BC94EA40D3E09E73F3E0257B;
        vin[3]  = 128'hC8B0DDB730C85055F237D1F894742066;
        vexp[3] = 128'h2A781B5B261EA7628F0C6F00E97A0A3F;
        @(posedge clk);
        #1;
        mif.dataIn = vin[0];
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (mif.resMat !== vexp[i]) begin
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, mif.resMat, vexp[i]);
            end else passed++;
            if (i < 3) begin
                mif.dataIn = vin[i+1];
                #1;
                total++;
                if (mif.resMat !== vexp[i]) begin
                    $display("FAIL midcycle_hold[%0d]: got %h expected %h", i, mif.resMat, vexp[i]);
                end else passed++;
            end
        end
    endtask

    task automatic test_vectors();
        logic [127:0] vin [2];
        logic [127:0] vexp [2];
        vin[0]  = 128'h876E46A6F24CE78C4D904AD897ECC395;
        vexp[0] = 128'h473794ED40D4E4A5A3703AA64C9F42BC;
        vin[1]  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        vexp[1] = 128'h046681e5e0cb199a48f8d37a2806264c;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            mif.dataIn = vin[i];
            @(posedge clk);
            #1;
            total++;
            if (mif.resMat !== vexp[i]) begin
                $display("FAIL vector[%0d]: got %h expected %h", i, mif.resMat, vexp[i]);
            end else passed++;
        end
    endtask

    task automatic test_edge_bytes();
        logic [31:0] cin [5];
        logic [31:0] cexp [5];
        cin[0] = 32'h00000000; cexp[0] = 32'h00000000;
        cin[1] = 32'h01010101; cexp[1] = 32'h01010101;
        cin[2] = 32'h80808080; cexp[2] = 32'h80808080;
        cin[3] = 32'hC6C6C6C6; cexp[3] = 32'hC6C6C6C6;
        cin[4] = 32'hF20A225C; cexp[4] = 32'h9FDC589D;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            mif.dataIn = {4{cin[i]}};
            @(posedge clk);
            #1;
            total++;
            if (mif.resMat !== {4{cexp[i]}}) begin
                $display("FAIL edge_bytes %h: got %h expected %h", cin[i], mif.resMat, {4{cexp[i]}});
            end else passed++;
        end
    endtask

    task automatic test_async_reset();
        logic [127:0] v;
        v = rand128();
        @(posedge clk);
        #1;
        mif.dataIn = v;
        @(posedge clk);
        #1;
        total++;
        if (mif.resMat !== ref_mix(v)) begin
            $display("FAIL pre_async_reset: got %h expected %h", mif.resMat, ref_mix(v));
        end else passed++;
        rst = 1'b1;
        #1;
        total++;
        if (mif.resMat !== 128'h0) begin
            $display("FAIL async_reset_mid: got %h expected %h", mif.resMat, 128'h0);
        end else passed++;
        @(posedge clk);
        #1;
        total++;
        if (mif.resMat !== 128'h0) begin
            $display("FAIL async_reset_edge: got %h expected %h", mif.resMat, 128'h0);
        end else passed++;
        v = rand128();
        mif.dataIn = v;
        rst = 1'b0;
        #1;
        total++;
        if (mif.resMat !== 128'h0) begin
            $display("FAIL post_release_hold: got %h expected %h", mif.resMat, 128'h0);
        end else passed++;
        @(posedge clk);
        #1;
        total++;
        if (mif.resMat !== ref_mix(v)) begin
            $display("FAIL post_release_load: got %h expected %h", mif.resMat, ref_mix(v));
        end else passed++;
    endtask

    task automatic test_random();
        logic [127:0] exp_q [$];
        logic [127:0] v;
        logic [127:0] e;
        for (int i = 0; i <= 1000; i++) begin
            @(posedge clk);
            #1;
            if (i > 0) begin
                e = exp_q.pop_front();
                total++;
                if (mif.resMat !== e) begin
                    $display("FAIL random[%0d]: got %h expected %h", i - 1, mif.resMat, e);
                end else passed++;
            end
            if (i < 1000) begin
                v = rand128();
                mif.dataIn = v;
                exp_q.push_back(ref_mix(v));
            end
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        mif.dataIn = '0;
        test_reset();
        test_constant();
        test_back_to_back();
        test_vectors();
        test_edge_bytes();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
